// File: rtl/mem_line_adapter.sv
// mem_line_adapter: presents a whole-cache-line request/response port to the
// client and turns each line request into one memory command followed by
// DATA_CYCLES write beats, or gathers DATA_CYCLES read beats into one line.
// One transaction is in flight at a time; the finished read line is held
// until the client takes it because the memory side cannot be stalled.
module mem_line_adapter #(
  parameter int ADDR_BITS   = 26,
  parameter int DATA_BITS   = 64,
  parameter int DATA_CYCLES = 4,
  parameter int TAG_BITS    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             line_req_valid,
  output logic                             line_req_ready,
  input  logic                             line_req_rw,
  input  logic [ADDR_BITS-1:0]             line_req_addr,
  input  logic [TAG_BITS-1:0]              line_req_tag,
  input  logic [DATA_BITS*DATA_CYCLES-1:0] line_req_data,
  output logic                             line_resp_valid,
  input  logic                             line_resp_ready,
  output logic [TAG_BITS-1:0]              line_resp_tag,
  output logic [DATA_BITS*DATA_CYCLES-1:0] line_resp_data,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_rw,
  output logic [ADDR_BITS-1:0]             mem_req_addr,
  output logic [TAG_BITS-1:0]              mem_req_tag,
  output logic                             mem_req_data_valid,
  input  logic                             mem_req_data_ready,
  output logic [DATA_BITS-1:0]             mem_req_data_bits,
  input  logic                             mem_resp_valid,
  input  logic [DATA_BITS-1:0]             mem_resp_data,
  input  logic [TAG_BITS-1:0]              mem_resp_tag,
  output logic                             resp_err
);

  localparam int CNT_BITS = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  // One-hot encoding: each per-state output is a flop bit of the state
  // register, so every handshake output comes straight from a register.
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CMD   = 5'b00010,
    S_WDATA = 5'b00100,
    S_RWAIT = 5'b01000,
    S_RESP  = 5'b10000
  } state_t;

  localparam int B_IDLE  = 0;
  localparam int B_CMD   = 1;
  localparam int B_WDATA = 2;
  localparam int B_RESP  = 4;

  state_t                                   state_q;
  logic [4:0]                               state_bits_s;
  logic [CNT_BITS-1:0]                      cnt_q;
  logic                                     rw_q;
  logic [ADDR_BITS-1:0]                     addr_q;
  logic [TAG_BITS-1:0]                      tag_q;
  logic [DATA_CYCLES-1:0][DATA_BITS-1:0]    wbuf_q;
  logic [DATA_CYCLES-1:0][DATA_BITS-1:0]    rbuf_q;
  logic [TAG_BITS-1:0]                      rtag_q;
  logic                                     err_q;

  // Sequencing of a line transaction, request capture, beat counting and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      // Any beat outside RWAIT, or a beat whose tag does not match, is a protocol error.
      if (mem_resp_valid) begin
        if (state_q != S_RWAIT) begin
          err_q <= 1'b1;
        end else if (mem_resp_tag != tag_q) begin
          err_q <= 1'b1;
        end else begin
          err_q <= err_q;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (line_req_valid) begin
            rw_q    <= line_req_rw;
            addr_q  <= line_req_addr;
            tag_q   <= line_req_tag;
            wbuf_q  <= line_req_data;
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (mem_req_ready) begin
            cnt_q   <= '0;
            state_q <= rw_q ? S_WDATA : S_RWAIT;
          end
        end
        S_WDATA: begin
          if (mem_req_data_ready) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_IDLE;
            end
          end
        end
        S_RWAIT: begin
          // A mismatching beat still lands in the buffer; only the flag records it.
          if (mem_resp_valid) begin
            rbuf_q[cnt_q] <= mem_resp_data;
            if (cnt_q == '0) begin
              rtag_q <= mem_resp_tag;
            end
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (line_resp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state_bits_s       = state_q;
  assign line_req_ready     = state_bits_s[B_IDLE];
  assign mem_req_valid      = state_bits_s[B_CMD];
  assign mem_req_data_valid = state_bits_s[B_WDATA];
  assign line_resp_valid    = state_bits_s[B_RESP];

  assign mem_req_rw         = rw_q;
  assign mem_req_addr       = addr_q;
  assign mem_req_tag        = tag_q;
  assign mem_req_data_bits  = wbuf_q[cnt_q];
  assign line_resp_tag      = rtag_q;
  assign line_resp_data     = rbuf_q;
  assign resp_err           = err_q;

endmodule

// File: tb/tb_mem_line_adapter.sv
// Bench for mem_line_adapter: table of line transactions with a scoreboard of
// expected memory commands, write beats and read lines, plus hand sequences
// for stray beats, tag errors and reset during a read.
module tb_mem_line_adapter;

  localparam int AB  = 26;
  localparam int DB  = 64;
  localparam int DC  = 4;
  localparam int TGB = 16;
  localparam int LB  = DB * DC;

  typedef logic [299:0] w_t;

  typedef struct {
    logic          rw;
    logic [AB-1:0] addr;
    logic [TGB-1:0] tag;
    logic [LB-1:0] line;
    int            cmd_stall;
    bit            toggle;
    int            gap;
    int            bp;
    int            bad_beat;
    int            exp_lat;
    logic [TGB-1:0] exp_rtag;
    logic          exp_err;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           line_req_valid, line_req_ready, line_req_rw;
  logic [AB-1:0]  line_req_addr;
  logic [TGB-1:0] line_req_tag;
  logic [LB-1:0]  line_req_data;
  logic           line_resp_valid, line_resp_ready;
  logic [TGB-1:0] line_resp_tag;
  logic [LB-1:0]  line_resp_data;
  logic           mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0]  mem_req_addr;
  logic [TGB-1:0] mem_req_tag;
  logic           mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0]  mem_req_data_bits;
  logic           mem_resp_valid;
  logic [DB-1:0]  mem_resp_data;
  logic [TGB-1:0] mem_resp_tag;
  logic           resp_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [AB+TGB:0]   cmd_q[$];
  logic [DB-1:0]     beat_q[$];
  logic [TGB+LB-1:0] resp_q[$];

  mem_line_adapter dut (
    .clk(clk), .reset(reset),
    .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
    .line_req_rw(line_req_rw), .line_req_addr(line_req_addr),
    .line_req_tag(line_req_tag), .line_req_data(line_req_data),
    .line_resp_valid(line_resp_valid), .line_resp_ready(line_resp_ready),
    .line_resp_tag(line_resp_tag), .line_resp_data(line_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_tag(mem_resp_tag), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired, got no handshake expected one", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every presented command, beat and line against the queue heads.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_q.size() == 0) begin
        chk("cmd_unexp", w_t'(mem_req_valid), w_t'(1'b0));
      end else if (mem_req_valid) begin
        chk("cmd", w_t'({mem_req_rw, mem_req_addr, mem_req_tag}), w_t'(cmd_q[0]));
        if (mem_req_ready) void'(cmd_q.pop_front());
      end
      if (beat_q.size() == 0) begin
        chk("beat_unexp", w_t'(mem_req_data_valid), w_t'(1'b0));
      end else if (mem_req_data_valid) begin
        chk("beat", w_t'(mem_req_data_bits), w_t'(beat_q[0]));
        if (mem_req_data_ready) void'(beat_q.pop_front());
      end
      if (resp_q.size() == 0) begin
        chk("resp_unexp", w_t'(line_resp_valid), w_t'(1'b0));
      end else if (line_resp_valid) begin
        chk("resp", w_t'({line_resp_tag, line_resp_data}), w_t'(resp_q[0]));
        if (line_resp_ready) void'(resp_q.pop_front());
      end
      if (line_resp_valid) chk("busy_in_resp", w_t'(line_req_ready), w_t'(1'b0));
    end
  end

  function automatic vec_t mk(input logic rw, input logic [AB-1:0] addr, input logic [TGB-1:0] tag,
                              input logic [LB-1:0] line, input int cmd_stall, input bit toggle,
                              input int gap, input int bp, input int bad_beat, input int exp_lat,
                              input logic [TGB-1:0] exp_rtag, input logic exp_err);
    vec_t v;
    v.rw = rw; v.addr = addr; v.tag = tag; v.line = line;
    v.cmd_stall = cmd_stall; v.toggle = toggle; v.gap = gap; v.bp = bp;
    v.bad_beat = bad_beat; v.exp_lat = exp_lat; v.exp_rtag = exp_rtag; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic wait_cmd_hs();
    int n;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) break;
      n++;
    end
    if (n >= 50) timeout("cmd_wait");
    step();
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int acc;
    n = 0;
    while (!line_req_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout("req_wait");
    line_req_valid = 1'b1;
    line_req_rw    = v.rw;
    line_req_addr  = v.addr;
    line_req_tag   = v.tag;
    line_req_data  = v.line;
    cmd_q.push_back({v.rw, v.addr, v.tag});
    if (v.rw) begin
      for (int k = 0; k < DC; k++) beat_q.push_back(v.line[k*DB +: DB]);
    end else begin
      resp_q.push_back({v.exp_rtag, v.line});
    end
    mem_req_ready      = (v.cmd_stall == 0);
    mem_req_data_ready = !v.toggle;
    step();
    acc = cyc;
    line_req_valid = 1'b0;
    for (int i = 0; i < v.cmd_stall; i++) step();
    mem_req_ready = 1'b1;
    if (v.rw) begin
      n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (line_req_ready) break;
        step();
        if (v.toggle) mem_req_data_ready = ~mem_req_data_ready;
        n++;
      end
      if (n >= 200) timeout("write_done");
      if (v.exp_lat != 0) chk("wr_latency", w_t'(cyc - acc + 1), w_t'(v.exp_lat));
      chk("beats_left", w_t'(beat_q.size()), w_t'(0));
    end else begin
      wait_cmd_hs();
      for (int k = 0; k < DC; k++) begin
        for (int g = 0; g < v.gap; g++) step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.line[k*DB +: DB];
        mem_resp_tag   = (k == v.bad_beat) ? (v.tag ^ 16'h000F) : v.tag;
        step();
        mem_resp_valid = 1'b0;
      end
      line_resp_ready = (v.bp == 0);
      @(negedge clk);
      chk("resp_latency", w_t'(line_resp_valid), w_t'(1'b1));
      for (int i = 0; i < v.bp; i++) step();
      line_resp_ready = 1'b1;
      step();
      line_resp_ready = 1'b0;
      @(negedge clk);
      chk("idle_after_resp", w_t'({line_req_ready, line_resp_valid}), w_t'(2'b10));
      chk("resp_left", w_t'(resp_q.size()), w_t'(0));
    end
    chk("err", w_t'(resp_err), w_t'(v.exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [LB-1:0] line_a;
    logic [LB-1:0] line_r;
    line_a = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    for (int i = 0; i < LB / 32; i++) line_r[i*32 +: 32] = $urandom;

    //               rw    addr          tag       line                       stall tog gap bp bad lat rtag      err
    vecs.push_back(mk(1'b1, 26'h10,      16'h0005, line_a,                    0, 1'b0, 0, 0, -1, 6, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 26'h10,      16'h0007, line_a,                    0, 1'b0, 0, 0, -1, 0, 16'h0007, 1'b0));
    vecs.push_back(mk(1'b0, 26'h155,     16'h1234, line_r,                    0, 1'b0, 1, 10, -1, 0, 16'h1234, 1'b0));
    vecs.push_back(mk(1'b1, 26'h3FFFFFF, 16'hFFFF, line_r,                    3, 1'b1, 0, 0, -1, 0, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 26'h0,       16'h0000, ~line_a,                   0, 1'b0, 2, 1, -1, 0, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b1, 26'h2AAAAAA, 16'h8001, ~line_r,                   0, 1'b0, 0, 0, -1, 6, 16'h0000, 1'b0));

    reset = 1'b1;
    line_req_valid = 1'b0; line_req_rw = 1'b0; line_req_addr = '0; line_req_tag = '0;
    line_req_data = '0; line_resp_ready = 1'b0; mem_req_ready = 1'b0;
    mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_tag = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_outputs", w_t'({line_req_ready, line_resp_valid, mem_req_valid, mem_req_data_valid, resp_err}),
        w_t'(5'b10000));
    step();
    reset = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Stray beat while idle: flag sets, adapter stays idle.
    step();
    mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF_0000_0001; mem_resp_tag = 16'h0007;
    step();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("stray_err", w_t'(resp_err), w_t'(1'b1));
    chk("stray_idle", w_t'({line_req_ready, mem_req_valid, line_resp_valid}), w_t'(3'b100));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("err_cleared", w_t'(resp_err), w_t'(1'b0));

    // Read whose third beat carries the wrong tag: flagged, line still delivered.
    run_txn(mk(1'b0, 26'h10, 16'h0007, line_a, 0, 1'b0, 0, 0, 2, 0, 16'h0007, 1'b1));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Reset after two of four read beats aborts the read.
    line_req_valid = 1'b1; line_req_rw = 1'b0; line_req_addr = 26'h20; line_req_tag = 16'h0009;
    mem_req_ready = 1'b1;
    cmd_q.push_back({1'b0, 26'h20, 16'h0009});
    step();
    line_req_valid = 1'b0;
    wait_cmd_hs();
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1'b1; mem_resp_data = line_r[k*DB +: DB]; mem_resp_tag = 16'h0009;
      step();
    end
    mem_resp_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_state", w_t'({line_req_ready, line_resp_valid, mem_req_valid, resp_err}), w_t'(4'b1000));
    step();
    run_txn(mk(1'b0, 26'h30, 16'h00C3, line_r, 0, 1'b0, 0, 0, -1, 0, 16'h00C3, 1'b0));

    chk("cmd_left", w_t'(cmd_q.size()), w_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
